// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator that scans out pixels from a sof-aligned FIFO
module vga_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] in_data,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        frame_start,
    output logic [15:0] underflow_count,
    output logic        locked
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   FULL   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic {SYNC, RUN} state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [24:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_q, rd_q;
    logic [24:0]   head;
    logic          empty, full, push, pop, show, uf, active, origin;
    logic [23:0]   rgb_q;
    logic          hs_q, vs_q, blank_q, fs_q;
    logic [15:0]   ucnt_q;

    assign h_d    = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    assign v_d    = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
    assign active = (h_q < H_VIS) && (v_q < V_VIS);
    assign origin = (h_q == '0) && (v_q == '0);
    assign empty  = wr_q == rd_q;
    assign full   = (wr_q - rd_q) == FULL;
    assign push   = in_valid && !full;
    assign head   = mem_q[rd_q[AW-1:0]];

    assign in_ready        = !full;
    assign {vga_r, vga_g, vga_b} = rgb_q;
    assign vga_hs          = hs_q;
    assign vga_vs          = vs_q;
    assign vga_blank_n     = blank_q;
    assign vga_sync_n      = 1'b0;
    assign frame_start     = fs_q;
    assign underflow_count = ucnt_q;
    assign locked          = state_q == RUN;

    // SYNC drops words until a sof word meets the origin; RUN takes one word per visible pixel
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        show    = 1'b0;
        uf      = 1'b0;
        if (state_q == SYNC) begin
            pop     = !empty && (!head[24] || origin);
            show    = pop && head[24];
            state_d = show ? RUN : SYNC;
        end else if (active) begin
            if (empty) begin
                uf      = 1'b1;
                state_d = SYNC;
            end else if (head[24] && !origin) begin
                state_d = SYNC;
            end else begin
                pop  = 1'b1;
                show = 1'b1;
            end
        end
    end

    // Raster counters, scanout state and FIFO pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_q     <= '0;
            v_q     <= '0;
            state_q <= SYNC;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            state_q <= state_d;
            wr_q    <= wr_q + (AW+1)'(push);
            rd_q    <= rd_q + (AW+1)'(pop);
        end
    end

    // FIFO storage holds {sof, data}; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {in_sof, in_data};
    end

    // Registered VGA outputs, one clock behind the counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            fs_q    <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            rgb_q   <= show ? head[23:0] : '0;
            hs_q    <= !(h_q >= HS_BEG && h_q < HS_END);
            vs_q    <= !(v_q >= VS_BEG && v_q < VS_END);
            blank_q <= active;
            fs_q    <= origin;
            ucnt_q  <= (uf && !(&ucnt_q)) ? ucnt_q + 1'b1 : ucnt_q;
        end
    end
endmodule
